// File: rtl/tetris_board.sv
// Tetris board-state engine: owns the settled-cell grid, moves a 2x2 falling piece,
// locks it on landing, clears full rows and counts them. arr feeds the VGA renderer.
module tetris_board #(
  parameter int COLS       = 10,
  parameter int ROWS       = 12,
  parameter int DROP_TICKS = 50_000_000
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      start,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_down,
  output logic [COLS-1:0][ROWS-1:0] arr,
  output logic [7:0]                score,
  output logic                      game_over
);
  localparam int PCW = (COLS > 2) ? $clog2(COLS) : 1;
  localparam int PRW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int CW  = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam int SC  = 4;
  localparam logic [PCW-1:0] SPAWN_C = PCW'(SC);
  localparam logic [PCW-1:0] C_MAX   = PCW'(COLS-2);
  localparam logic [PRW-1:0] R_MAX   = PRW'(ROWS-2);
  localparam logic [PRW-1:0] R_LAST  = PRW'(ROWS-1);
  localparam logic [CW-1:0]  TICK    = CW'(DROP_TICKS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FALL, S_LOCK, S_SCAN, S_SHIFT, S_OVER
  } state_e;

  state_e                    state_q;
  logic [COLS-1:0][ROWS-1:0] board_q, piece, board_shift, arr_q;
  logic [PCW-1:0]            pc_q, pc_p1, pc_p2, pc_m1;
  logic [PRW-1:0]            pr_q, pr_p1, pr_p2, sr_q;
  logic [CW-1:0]             cnt_q;
  logic [7:0]                score_q, score_out_q;
  logic                      game_over_q;
  logic                      tick, can_down, can_left, can_right, spawn_hit, row_full;

  // Neighbour reads use wrapped indices; every such read is masked by its edge guard.
  always_comb begin
    pc_p1     = pc_q + 1'b1;
    pc_p2     = pc_q + PCW'(2);
    pc_m1     = pc_q - 1'b1;
    pr_p1     = pr_q + 1'b1;
    pr_p2     = pr_q + PRW'(2);
    tick      = (cnt_q == TICK);
    can_down  = (pr_q != R_MAX) && !board_q[pc_q][pr_p2] && !board_q[pc_p1][pr_p2];
    can_left  = (pc_q != '0)    && !board_q[pc_m1][pr_q] && !board_q[pc_m1][pr_p1];
    can_right = (pc_q != C_MAX) && !board_q[pc_p2][pr_q] && !board_q[pc_p2][pr_p1];
    spawn_hit = board_q[SC][0] | board_q[SC+1][0] | board_q[SC][1] | board_q[SC+1][1];
  end

  always_comb begin
    piece                = '0;
    piece[pc_q][pr_q]    = 1'b1;
    piece[pc_p1][pr_q]   = 1'b1;
    piece[pc_q][pr_p1]   = 1'b1;
    piece[pc_p1][pr_p1]  = 1'b1;
  end

  // Row sr collapses: everything at or above sr moves down one, row 0 empties.
  always_comb begin
    row_full    = 1'b1;
    board_shift = board_q;
    for (int c = 0; c < COLS; c++) begin
      row_full = row_full & board_q[c][sr_q];
      for (int r = 1; r < ROWS; r++)
        if (PRW'(r) <= sr_q) board_shift[c][r] = board_q[c][r-1];
      board_shift[c][0] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      board_q     <= '0;
      pc_q        <= '0;
      pr_q        <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      score_q     <= '0;
      arr_q       <= '0;
      score_out_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      arr_q       <= (state_q == S_FALL) ? (board_q | piece) : board_q;
      score_out_q <= score_q;
      game_over_q <= (state_q == S_OVER);
      case (state_q)
        S_IDLE: if (start) state_q <= S_SPAWN;
        S_SPAWN: begin
          pc_q    <= SPAWN_C;
          pr_q    <= '0;
          cnt_q   <= '0;
          state_q <= spawn_hit ? S_OVER : S_FALL;
        end
        S_FALL: begin
          cnt_q <= cnt_q + 1'b1;
          if (tick || btn_down) begin
            if (can_down) begin
              pr_q  <= pr_p1;
              cnt_q <= '0;
            end else begin
              state_q <= S_LOCK;
            end
          end else if (btn_left) begin
            if (can_left) pc_q <= pc_m1;
          end else if (btn_right) begin
            if (can_right) pc_q <= pc_p1;
          end
        end
        S_LOCK: begin
          board_q <= board_q | piece;
          sr_q    <= R_LAST;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (row_full)          state_q <= S_SHIFT;
          else if (sr_q == '0)   state_q <= S_SPAWN;
          else                   sr_q    <= sr_q - 1'b1;
        end
        S_SHIFT: begin
          board_q <= board_shift;
          if (score_q != 8'hFF) score_q <= score_q + 1'b1;
          state_q <= S_SCAN;
        end
        S_OVER: begin
          if (start) begin
            board_q <= '0;
            score_q <= '0;
            state_q <= S_SPAWN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arr       = arr_q;
  assign score     = score_out_q;
  assign game_over = game_over_q;
endmodule

// File: tb/tb_tetris_board.sv
// Bench for tetris_board: a game-level reference model (grid array, piece origin,
// row compaction on lock) predicts the registered outputs one cycle behind.
module tb_tetris_board;
  localparam int C  = 10;
  localparam int R  = 12;
  localparam int DT = 4;
  typedef logic [C-1:0][R-1:0] grid_t;
  typedef enum int {M_IDLE, M_SPAWN, M_FALL, M_BUSY, M_OVER} mph_e;

  logic  Clk = 0, Reset_n = 1, start = 0, btn_left = 0, btn_right = 0, btn_down = 0;
  grid_t arr;
  logic [7:0] score;
  logic  game_over;

  int    checks = 0, failures = 0;
  bit    mb [C][R];
  int    mpc, mpr, mcnt, mbusy, mscore, nlocks;
  mph_e  mph;
  grid_t exp_arr, sp;
  logic [7:0] exp_score;
  logic  exp_go;
  bit    exp_ok;

  tetris_board #(.COLS(C), .ROWS(R), .DROP_TICKS(DT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .btn_left(btn_left),
    .btn_right(btn_right), .btn_down(btn_down), .arr(arr), .score(score),
    .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  function automatic grid_t view();
    grid_t v = '0;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++) v[c][r] = mb[c][r];
    if (mph == M_FALL) begin
      v[mpc][mpr] = 1'b1; v[mpc+1][mpr] = 1'b1;
      v[mpc][mpr+1] = 1'b1; v[mpc+1][mpr+1] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_reset();
    foreach (mb[c, r]) mb[c][r] = 1'b0;
    mph = M_IDLE; mpc = 0; mpr = 0; mcnt = 0; mbusy = 0; mscore = 0;
  endtask

  // Landing: merge, drop every full row and compact, then stay busy for the clear sequence.
  task automatic lock_piece();
    bit nb [C][R];
    bit full;
    int dst, k;
    mb[mpc][mpr] = 1; mb[mpc+1][mpr] = 1; mb[mpc][mpr+1] = 1; mb[mpc+1][mpr+1] = 1;
    foreach (nb[c, r]) nb[c][r] = 1'b0;
    dst = R - 1; k = 0;
    for (int r = R - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < C; c++) full &= mb[c][r];
      if (full) k++;
      else begin
        for (int c = 0; c < C; c++) nb[c][dst] = mb[c][r];
        dst--;
      end
    end
    mb = nb;
    mscore = (mscore + k > 255) ? 255 : mscore + k;
    mbusy = 1 + R + 2 * k;
    mph = M_BUSY;
    nlocks++;
  endtask

  task automatic model_step(input bit st, input bit l, input bit rt, input bit d);
    bit tick;
    case (mph)
      M_IDLE: if (st) mph = M_SPAWN;
      M_SPAWN: begin
        mpc = 4; mpr = 0; mcnt = 0;
        mph = (mb[4][0] || mb[5][0] || mb[4][1] || mb[5][1]) ? M_OVER : M_FALL;
      end
      M_FALL: begin
        tick = (mcnt == DT - 1);
        mcnt++;
        if (tick || d) begin
          if (mpr + 2 <= R - 1 && !mb[mpc][mpr+2] && !mb[mpc+1][mpr+2]) begin
            mpr++; mcnt = 0;
          end else lock_piece();
        end else if (l) begin
          if (mpc > 0 && !mb[mpc-1][mpr] && !mb[mpc-1][mpr+1]) mpc--;
        end else if (rt) begin
          if (mpc + 2 <= C - 1 && !mb[mpc+2][mpr] && !mb[mpc+2][mpr+1]) mpc++;
        end
      end
      M_BUSY: begin
        mbusy--;
        if (mbusy == 0) mph = M_SPAWN;
      end
      M_OVER: if (st) begin
        foreach (mb[c, r]) mb[c][r] = 1'b0;
        mscore = 0;
        mph = M_SPAWN;
      end
      default: mph = M_IDLE;
    endcase
  endtask

  // One clock: snapshot what the outputs must show after this edge, drive, step the model.
  task automatic cycle(input bit st, input bit l, input bit rt, input bit d);
    exp_arr = view(); exp_score = 8'(mscore); exp_go = (mph == M_OVER); exp_ok = (mph != M_BUSY);
    start = st; btn_left = l; btn_right = rt; btn_down = d;
    @(posedge Clk);
    model_step(st, l, rt, d);
    #1;
    start = 0; btn_left = 0; btn_right = 0; btn_down = 0;
  endtask

  task automatic do_reset();
    #2 Reset_n = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1;
  endtask

  task automatic place(input int target);
    int guard = 0;
    while (mph != M_FALL && guard < 100) begin
      cycle(0, 0, 0, 0); guard++;
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL place_wait: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
    while (mph == M_FALL && mpc != target && guard < 100) begin
      cycle(0, mpc > target, mpc < target, 0); guard++;
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL place_move: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
    while (mph == M_FALL && guard < 100) begin
      cycle(0, 0, 0, 1); guard++;
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL place_drop: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
    if (guard >= 100) begin checks++; failures++; $display("FAIL place_timeout: target=%0d pc=%0d required lock within 100 cycles", target, mpc); end
  endtask

  task automatic wait_phase(input mph_e ph);
    int guard = 0;
    while (mph != ph && guard < 200) begin
      cycle(0, 0, 0, 0); guard++;
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL wait_phase: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
    if (mph != ph) begin checks++; failures++; $display("FAIL wait_timeout: phase=%0d required %0d within 200 cycles", mph, ph); end
  endtask

  task automatic test_reset();
    #3 Reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (arr !== '0 || score !== 8'd0 || game_over !== 1'b0) begin failures++; $display("FAIL reset: arr=%h score=%0d go=%b required all 0", arr, score, game_over); end
    @(posedge Clk); #1 Reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(0, i[0], i[1], i[2]);
      checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL idle: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end
    end
  endtask

  task automatic test_spawn();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(i == 0, 0, 0, 0);
      checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL spawn_seq: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end
    end
    checks++;
    if (arr !== sp || score !== 8'd0) begin failures++; $display("FAIL spawn: arr=%h score=%0d required arr=%h score=0", arr, score, sp); end
  endtask

  task automatic test_gravity();
    int n0 = nlocks;
    int guard = 0;
    while (!(nlocks > n0 && mph == M_FALL) && guard < 200) begin
      cycle(0, 0, 0, 0); guard++;
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL gravity: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
    cycle(0, 0, 0, 0);
    checks++;
    if ({arr[4][11], arr[4][10], arr[5][11], arr[5][10], arr[4][1], arr[4][0], arr[5][1], arr[5][0]} !== 8'hFF
        || $countones(arr) != 8) begin
      failures++; $display("FAIL landed: arr=%h required bottom block at cols 4-5 rows 10-11 plus spawn", arr);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0);
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL left: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (arr[0] == '0 || arr[1] == '0 || arr[2] != '0 || arr[9] != '0) begin failures++; $display("FAIL clamp_left: arr=%h required piece in cols 0-1 only", arr); end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 1, 0);
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL right: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (arr[8] == '0 || arr[9] == '0 || arr[7] != '0 || arr[0] != '0) begin failures++; $display("FAIL clamp_right: arr=%h required piece in cols 8-9 only", arr); end
  endtask

  task automatic test_clear();
    do_reset();
    cycle(1, 0, 0, 0);
    for (int p = 0; p < 5; p++) place(2 * p);
    wait_phase(M_FALL);
    cycle(0, 0, 0, 0);
    checks++;
    if (score !== 8'd2 || arr !== sp) begin failures++; $display("FAIL clear: arr=%h score=%0d required arr=%h score=2", arr, score, sp); end
  endtask

  task automatic test_game_over();
    grid_t stack = '0;
    stack[4] = '1; stack[5] = '1;
    do_reset();
    cycle(1, 0, 0, 0);
    for (int p = 0; p < 6; p++) place(4);
    wait_phase(M_OVER);
    cycle(0, 0, 0, 0);
    checks++;
    if (game_over !== 1'b1 || arr !== stack) begin failures++; $display("FAIL over: arr=%h go=%b required arr=%h go=1", arr, game_over, stack); end
    for (int i = 0; i < 6; i++) begin
      cycle(0, i[0], i[1], 1);
      checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL frozen: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end
    end
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    checks++;
    if (game_over !== 1'b0 || score !== 8'd0 || arr !== '0) begin failures++; $display("FAIL restart: arr=%h score=%0d go=%b required all 0", arr, score, game_over); end
    cycle(0, 0, 0, 0);
    checks++;
    if (arr !== sp) begin failures++; $display("FAIL respawn: arr=%h required %h", arr, sp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    #2 Reset_n = 0; #1;
    checks++;
    if (arr !== '0 || score !== 8'd0 || game_over !== 1'b0) begin failures++; $display("FAIL reset_fall: arr=%h score=%0d go=%b required all 0", arr, score, game_over); end
    model_reset();
    @(posedge Clk); #1 Reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 1);
      checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL post_reset_idle: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end
    end
    cycle(1, 0, 0, 0);
    for (int p = 0; p < 5; p++) place(2 * p);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    checks++;
    if ($countones(arr) != 20) begin failures++; $display("FAIL pre_shift: ones=%0d required 20", $countones(arr)); end
    #2 Reset_n = 0; #1;
    checks++;
    if (arr !== '0 || score !== 8'd0 || game_over !== 1'b0) begin failures++; $display("FAIL reset_shift: arr=%h score=%0d go=%b required all 0", arr, score, game_over); end
    model_reset();
    @(posedge Clk); #1 Reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0);
      checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL post_shift_idle: arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", arr, score, game_over, exp_arr, exp_score, exp_go); end
    end
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    checks++;
    if (arr !== sp || score !== 8'd0) begin failures++; $display("FAIL post_reset_spawn: arr=%h score=%0d required arr=%h score=0", arr, score, sp); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      if (exp_ok) begin checks++; if ({arr, score, game_over} !== {exp_arr, exp_score, exp_go}) begin failures++; $display("FAIL random: cyc=%0d arr=%h score=%0d go=%b expected arr=%h score=%0d go=%b", i, arr, score, game_over, exp_arr, exp_score, exp_go); end end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    nlocks = 0;
    sp = '0;
    sp[4][0] = 1'b1; sp[4][1] = 1'b1; sp[5][0] = 1'b1; sp[5][1] = 1'b1;
    model_reset();
    test_reset();
    test_spawn();
    test_gravity();
    test_clamp();
    test_clear();
    test_game_over();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tetris_board.md
# tetris_board

Board-state engine for the Tetris game. It owns the 10-column × 12-row occupancy grid and moves a falling 2×2 piece under gravity and player input. It locks the piece when it lands, clears full rows and counts them. Its `arr` output is the occupancy map read by the VGA pixel renderer, so this block is the writer side of the board interface.

## Interface
- `COLS`, default 10: board columns (horizontal, index 0 = left).
- `ROWS`, default 12: board rows (vertical, index 0 = top).
- `DROP_TICKS`, default 50_000_000: Clk cycles per gravity step. Use 4 in simulation.
- `Clk`, input, 1: system clock. One clock domain only.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle pulse that starts a game or restarts after game over.
- `btn_left`, `btn_right`, `btn_down`, inputs, 1 each: single-cycle pulses, already debounced and synchronised upstream.
- `arr`, output, [COLS-1:0][ROWS-1:0]: `arr[c][r]` = 1 when cell (c, r) is settled or holds the active piece.
- `score`, output, 8: count of rows cleared. Saturates at 255.
- `game_over`, output, 1: high while in OVER.

## Operation
- Internal state:
  - `board[c][r]`: settled cells.
  - Piece origin (`pc`, `pr`): top-left cell. The piece occupies (pc, pr), (pc+1, pr), (pc, pr+1), (pc+1, pr+1).
  - Drop counter, width clog2(DROP_TICKS).
  - Scan row `sr`.
- States:
  - **IDLE**: waits. `start` → SPAWN.
  - **SPAWN**, 1 cycle:
    - Sets pc=4, pr=0 and clears the drop counter.
    - If any of the 4 spawn cells is set in `board` → OVER; otherwise → FALL.
  - **FALL**: the drop counter increments every cycle. A tick is counter == DROP_TICKS-1. At most one action per cycle, in this priority:
    - Tick or `btn_down`: drop. If pr+2 ≤ ROWS-1 and `board[pc][pr+2]`, `board[pc+1][pr+2]` are both 0 → pr++ and clear the counter. Otherwise → LOCK.
    - `btn_left`: if pc > 0 and both cells in column pc-1 (rows pr, pr+1) are empty → pc--. Otherwise ignore.
    - `btn_right`: if pc+2 ≤ COLS-1 and both cells in column pc+2 are empty → pc++. Otherwise ignore.
    - A lower-priority pulse that arrives in the same cycle as a higher-priority action is discarded, not queued.
    - A tick and `btn_down` in the same cycle produce one drop only.
  - **LOCK**, 1 cycle: ORs the 4 piece cells into `board`, sets sr = ROWS-1 → SCAN.
  - **SCAN**, 1 cycle:
    - If row sr is full across all COLS → SHIFT.
    - Else if sr == 0 → SPAWN.
    - Else sr-- and stay in SCAN.
  - **SHIFT**, 1 cycle:
    - For r = sr down to 1, row r takes row r-1; row 0 becomes 0.
    - score++, saturating at 255.
    - → SCAN with the same sr, so the row that dropped into sr is re-checked.
  - **OVER**: `board` is frozen; buttons are ignored. `start` clears `board` and score, drops `game_over` → SPAWN.
- `start` is ignored outside IDLE and OVER.
- Piece cells contribute to `arr` only in FALL. In all other states `arr` shows `board` alone.

## Timing
- Reset values: `arr`=0, `score`=0, `game_over`=0, `board`=0, state IDLE, counter 0.
  - Reset takes effect immediately and asynchronously, from any state, including mid-SHIFT.
- `arr`, `score` and `game_over` are registered. Each reflects the state after the clock edge and is valid 1 cycle after that edge.
- `start` in IDLE: edge N → SPAWN, N+1 → FALL. The piece is visible in `arr` after edge N+2.
- Button pulse in FALL at edge N: the move is reflected in `arr` after edge N+1.
- Gravity: with no input, one row per DROP_TICKS cycles.
- Landing to next spawn: 1 LOCK cycle + (ROWS + k) SCAN cycles + k SHIFT cycles + 1 SPAWN cycle, where k = rows cleared.

## Test plan
- Reset, then `start` with DROP_TICKS=4 → `arr` bits [4][0], [4][1], [5][0], [5][1] set; all other bits 0; `score`=0.
- No input → the piece reaches rows 10–11 after 10 drops and locks. `arr[4][10]`, `[4][11]`, `[5][10]`, `[5][11]` stay set and a new piece appears at rows 0–1.
- 10 `btn_left` pulses → pc clamps at 0; `arr` column 0 shows the piece and nothing wraps to column 9. Repeat with `btn_right` → pc clamps at 8.
- Place pieces at pc = 0, 2, 4, 6, 8 and let each fall → rows 10 and 11 become full and both clear. `score`=2 and `arr` returns to all 0 apart from the new spawn.
- Let six pieces fall at pc=4 → column 4–5 fills rows 0–11. The next SPAWN collides → `game_over`=1 and `arr` is frozen. `start` → `board` cleared, `score`=0, `game_over`=0, new piece spawned.
- Assert `Reset_n` low mid-FALL and mid-SHIFT → all outputs 0 immediately. After release the block idles until `start`.
